grn_attractor_ctrl: RTL and testbench
=====================================

Name: grn_attractor_ctrl

Overview:
Sequencer and observer for an array of two-copy Boolean network nodes, where each node holds a tortoise state s0 and a hare state s1. For each initial state in a programmed range, the block:
- loads the state into every node with reset_nos/init_state,
- steps the nodes with start_s0/start_s1 until the tortoise and hare vectors meet (Floyd cycle detection),
- optionally measures the attractor period,
- emits one result record per initial state over a valid/ready port.

Parameters:
NUM_NODES, 8, number of network nodes; width of every state vector
CNT_W, 16, width of step and period counters
MAX_STEPS, 1000, step limit per phase before timeout; must be ≤ 2^CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begin a run; ignored unless busy=0
init_first  in  NUM_NODES  first initial state; latched on start
init_last  in  NUM_NODES  last initial state (inclusive); latched on start
s0_vec  in  NUM_NODES  concatenated tortoise outputs of all nodes
s1_vec  in  NUM_NODES  concatenated hare outputs of all nodes
reset_nos  out  1  load pulse to all nodes
init_state  out  NUM_NODES  per-node load value; bit i goes to node i
start_s0  out  1  tortoise step enable
start_s1  out  1  hare step enable
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last record is accepted
out_valid  out  1  result record valid
out_ready  in  1  result record accepted when high with out_valid
out_init  out  NUM_NODES  initial state of this record
out_meet_steps  out  CNT_W  hare steps taken at first meet
out_period  out  CNT_W  attractor period; 0 if not measured or timed out
out_timeout  out  1  step limit hit in either phase

Behaviour:
- Node contract:
  - Nodes update one cycle after an asserted enable.
  - The tortoise updates only on odd-numbered start_s0 pulses after a load; its internal pass flag is set by reset_nos.
  - The hare updates on every start_s1 pulse.
- Reset: all outputs 0; FSM returns to IDLE; counters cleared. rst has priority over every other input and aborts any state.
- FSM states:
  - IDLE: wait for start; latch the range; cur = init_first; go to LOAD.
  - LOAD: reset_nos=1, init_state=cur for one cycle; steps=0, period=0; go to STEP.
  - STEP: start_s0=1 and start_s1=1 for one cycle; steps++; go to CHECK.
  - CHECK:
    - If steps≥2 and s0_vec==s1_vec: go to PSTEP (feature on) or OUT.
    - Else if steps==MAX_STEPS: timeout=1, go to OUT.
    - Else go to STEP.
    - The compare is ignored at steps<2, because after one step both copies have advanced once and are trivially equal.
  - PSTEP: start_s1=1 only; the tortoise is frozen; period++; go to PCHECK.
  - PCHECK:
    - If s1_vec==s0_vec: go to OUT.
    - Else if period==MAX_STEPS: timeout=1, period field=0, go to OUT.
    - Else go to PSTEP.
  - OUT:
    - out_valid=1; record fields are stable and no node enables are driven while waiting.
    - On out_ready: if cur==init_last go to DONE, else cur = cur+1 mod 2^NUM_NODES and go to LOAD.
  - DONE: done=1 for one cycle; busy=0; go to IDLE.
- Latency: each step costs 2 cycles; each record costs 1 + 2·meet_steps + 2·period + 1 cycles, plus any backpressure stall.
- Range: enumeration wraps modulo 2^NUM_NODES.
  - init_first==init_last gives exactly one record.
  - init_last==init_first-1 covers every state.
- Enable outputs are 0 in every state not listed above.
- start while busy is ignored. The range is not re-latched mid-run.

Optional Feature:
GRN_CTRL_PERIOD_EN:
- Defined: PSTEP/PCHECK are included and out_period holds the measured period (≥1).
- Undefined: CHECK goes directly to OUT on meet, and out_period is tied to 0.

Test Plan:
- Fixed-point network (next=state), NUM_NODES=2, first=last=3 → one record: init=3, meet_steps=2, period=1, timeout=0; done 1 cycle after ready.
- 2-bit increment network (cycle of 4), first=last=0 → meet_steps=8, period=4, timeout=0.
- 4-bit increment network, MAX_STEPS=8 → meet_steps=8, timeout=1, period=0; next init proceeds normally.
- Range wrap, NUM_NODES=2, first=3, last=1 → records in order init 3, 0, 1; exactly one done pulse; busy falls with done.
- out_ready held low 5 cycles in OUT → out_valid and all fields stable; reset_nos, start_s0 and start_s1 stay 0; progress resumes the cycle after ready.
- rst asserted during STEP → next cycle all outputs 0 and FSM in IDLE; a start pulse during the same rst cycle is ignored; a later start runs cleanly.

Source files
------------

// File: rtl/grn_attractor_ctrl.sv
// grn_attractor_ctrl: Floyd cycle-detection sequencer over a range of initial network states.
// Defining GRN_CTRL_PERIOD_EN adds attractor period measurement after the first meet.
module grn_attractor_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_first,
  input  logic [NUM_NODES-1:0] init_last,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_NODES-1:0] out_init,
  output logic [CNT_W-1:0]     out_meet_steps,
  output logic [CNT_W-1:0]     out_period,
  output logic                 out_timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, STEP, CHECK, PSTEP, PCHECK, OUT, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_STEPS);
  state_t state_q;
  logic [NUM_NODES-1:0] cur_q, last_q;
  logic [CNT_W-1:0] steps_q;
  logic timeout_q, reset_nos_q, s0_q, s1_q, busy_q, done_q, valid_q;
  logic meet;
`ifdef GRN_CTRL_PERIOD_EN
  logic [CNT_W-1:0] period_q;
  assign out_period = period_q;
`else
  assign out_period = '0;
`endif
  assign meet = s0_vec == s1_vec;
  assign reset_nos = reset_nos_q;
  assign init_state = cur_q;
  assign start_s0 = s0_q;
  assign start_s1 = s1_q;
  assign busy = busy_q;
  assign done = done_q;
  assign out_valid = valid_q;
  assign out_init = cur_q;
  assign out_meet_steps = steps_q;
  assign out_timeout = timeout_q;
  // Enable and pulse outputs are registered: each is set on the edge entering the state that drives it.
  always_ff @(posedge clk) begin
    reset_nos_q <= 1'b0;
    s0_q <= 1'b0;
    s1_q <= 1'b0;
    done_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      last_q <= '0;
      steps_q <= '0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef GRN_CTRL_PERIOD_EN
      period_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cur_q <= init_first;
          last_q <= init_last;
          busy_q <= 1'b1;
          reset_nos_q <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          steps_q <= '0;
          timeout_q <= 1'b0;
`ifdef GRN_CTRL_PERIOD_EN
          period_q <= '0;
`endif
          s0_q <= 1'b1;
          s1_q <= 1'b1;
          state_q <= STEP;
        end
        STEP: begin
          steps_q <= steps_q + CNT_W'(1);
          state_q <= CHECK;
        end
        // After a single step both copies moved once, so equality there means nothing.
        CHECK: if (steps_q >= CNT_W'(2) && meet) begin
`ifdef GRN_CTRL_PERIOD_EN
          s1_q <= 1'b1;
          state_q <= PSTEP;
`else
          valid_q <= 1'b1;
          state_q <= OUT;
`endif
        end else if (steps_q == MAX) begin
          timeout_q <= 1'b1;
          valid_q <= 1'b1;
          state_q <= OUT;
        end else begin
          s0_q <= 1'b1;
          s1_q <= 1'b1;
          state_q <= STEP;
        end
`ifdef GRN_CTRL_PERIOD_EN
        PSTEP: begin
          period_q <= period_q + CNT_W'(1);
          state_q <= PCHECK;
        end
        PCHECK: if (meet) begin
          valid_q <= 1'b1;
          state_q <= OUT;
        end else if (period_q == MAX) begin
          timeout_q <= 1'b1;
          period_q <= '0;
          valid_q <= 1'b1;
          state_q <= OUT;
        end else begin
          s1_q <= 1'b1;
          state_q <= PSTEP;
        end
`endif
        OUT: if (out_ready) begin
          valid_q <= 1'b0;
          if (cur_q == last_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cur_q <= cur_q + NUM_NODES'(1);
            reset_nos_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// tb_grn_attractor_ctrl: scoreboard bench driving a behavioural two-copy node array.
module tb_grn_attractor_ctrl;
  localparam int N = 4, W = 16, MS = 8;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [N-1:0] init_first = '0, init_last = '0, s0_vec = '0, s1_vec = '0;
  logic reset_nos, start_s0, start_s1, busy, done, out_valid, out_timeout;
  logic [N-1:0] init_state, out_init;
  logic [W-1:0] out_meet_steps, out_period;
  int n_chk = 0, n_fail = 0, done_cnt = 0, mode = 0;
  logic pass = 1'b0;
  typedef struct {logic [N-1:0] init; int meet; int per; bit to; bit last;} rec_t;
  rec_t exp_q[$];
  logic hold = 0, acc = 0, acc_last = 0, h_to;
  logic [N-1:0] h_init;
  logic [W-1:0] h_meet, h_per;

  grn_attractor_ctrl #(.NUM_NODES(N), .CNT_W(W), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .init_first(init_first), .init_last(init_last),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_init(out_init),
    .out_meet_steps(out_meet_steps), .out_period(out_period), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // mode 0: fixed point, 1: 2-bit increment (cycle of 4), 2: 4-bit increment (cycle of 16)
  function automatic logic [N-1:0] f(input logic [N-1:0] x);
    return mode == 0 ? x : mode == 1 ? {x[3:2], x[1:0] + 2'd1} : x + 4'd1;
  endfunction

  always @(posedge clk)
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      pass <= 1'b1;
    end else begin
      if (start_s0) begin
        if (pass) s0_vec <= f(s0_vec);
        pass <= ~pass;
      end
      if (start_s1) s1_vec <= f(s1_vec);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (acc) begin
        if (acc_last) begin
          chk("done_after_last_accept", done, 1);
          chk("busy_low_with_done", busy, 0);
        end else chk("reload_after_accept", reset_nos, 1);
      end
      if (hold) begin
        chk("valid_held", out_valid, 1);
        chk("init_stable", out_init, h_init);
        chk("meet_stable", out_meet_steps, h_meet);
        chk("period_stable", out_period, h_per);
        chk("timeout_stable", out_timeout, h_to);
      end
      acc = 0;
      hold = 0;
      if (out_valid === 1'b1) begin
        chk("no_enables_in_out", {reset_nos, start_s0, start_s1}, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("record_expected", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("rec_init", out_init, e.init);
            chk("rec_meet_steps", out_meet_steps, e.meet);
            chk("rec_period", out_period, e.per);
            chk("rec_timeout", out_timeout, e.to);
            acc = 1;
            acc_last = e.last;
          end
        end else begin
          hold = 1;
          h_init = out_init;
          h_meet = out_meet_steps;
          h_per = out_period;
          h_to = out_timeout;
        end
      end
    end
  end

  task automatic run(input int m, input logic [N-1:0] first, input logic [N-1:0] last,
                     input int meet, input int per, input bit to, input int stall);
    logic [N-1:0] c;
    int cnt, pe;
`ifdef GRN_CTRL_PERIOD_EN
    pe = per;
`else
    pe = 0;
`endif
    mode = m;
    c = first;
    forever begin
      exp_q.push_back('{c, meet, pe, to, c == last});
      if (c == last) break;
      c = c + 4'd1;
    end
    done_cnt = 0;
    out_ready = (stall == 0);
    init_first = first;
    init_last = last;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    init_first = ~first;
    init_last = ~last;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    if (stall > 0) begin
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 500) begin
        @(posedge clk) #1;
        cnt++;
      end
      chk("valid_before_stall", out_valid, 1);
      repeat (stall) @(posedge clk) #1;
      out_ready = 1;
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      @(posedge clk) #1;
      cnt++;
    end
    chk("done_seen", done, 1);
    chk("busy_falls_with_done", busy, 0);
    @(posedge clk) #1;
    chk("done_single_cycle", done, 0);
    chk("done_pulse_count", done_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {reset_nos, init_state, start_s0, start_s1, busy, done, out_valid,
        out_init, out_meet_steps, out_period, out_timeout}, 0);
    rst = 0;
    @(posedge clk) #1;
    run(0, 4'd3, 4'd3, 2, 1, 0, 0);
    run(1, 4'd0, 4'd0, 8, 4, 0, 0);
    run(2, 4'd5, 4'd6, MS, 0, 1, 0);
    run(0, 4'd15, 4'd1, 2, 1, 0, 0);
    run(1, 4'd2, 4'd2, 8, 4, 0, 5);
    run(0, 4'd5, 4'd4, 2, 1, 0, 0);
    mode = 1;
    init_first = 0;
    init_last = 0;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    @(posedge clk) #1;
    chk("in_step_before_rst", {start_s0, start_s1}, 2'b11);
    rst = 1;
    start = 1;
    @(posedge clk) #1;
    rst = 0;
    start = 0;
    chk("rst_clears_outputs", {reset_nos, init_state, start_s0, start_s1, busy, done, out_valid,
        out_init, out_meet_steps, out_period, out_timeout}, 0);
    @(posedge clk) #1;
    chk("start_in_rst_ignored", {busy, reset_nos}, 0);
    exp_q.delete();
    run(0, 4'd3, 4'd3, 2, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
